// File: rtl/fetch_seq_if.sv
// Host <-> fetch sequencer bundle: control strobes, LUT write port and
// the sequencer's status outputs.
interface fetch_seq_if #(
  parameter int PC_W   = 12,
  parameter int LUT_AW = 3
);
  logic              req;
  logic              stall;
  logic              br_en;
  logic              abs_en;
  logic              call_en;
  logic              ret_en;
  logic              halt;
  logic [LUT_AW-1:0] lut_idx;
  logic              lut_we;
  logic [LUT_AW-1:0] lut_waddr;
  logic [PC_W-1:0]   lut_wdata;
  logic [PC_W-1:0]   prog_ctr;
  logic              run;
  logic              done;
  logic              fault;
  logic [15:0]       cyc_cnt;

  modport master (
    output req, stall, br_en, abs_en, call_en, ret_en, halt,
           lut_idx, lut_we, lut_waddr, lut_wdata,
    input  prog_ctr, run, done, fault, cyc_cnt
  );

  modport slave (
    input  req, stall, br_en, abs_en, call_en, ret_en, halt,
           lut_idx, lut_we, lut_waddr, lut_wdata,
    output prog_ctr, run, done, fault, cyc_cnt
  );
endinterface

// File: rtl/fetch_seq.sv
// Fetch sequencer: walks a PC through a program with relative branches,
// absolute jumps and call/return via a small return-address stack.
// Jump targets come from a host-writable LUT. STK_D must be >= 2.
module fetch_seq #(
  parameter int PC_W     = 12,
  parameter int LUT_AW   = 3,
  parameter int STK_D    = 4,
  parameter int END_ADDR = 128
) (
  input logic        clk,
  input logic        reset,
  fetch_seq_if.slave bus
);
  localparam int SP_W = $clog2(STK_D + 1);
  localparam int IX_W = $clog2(STK_D);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STK_D);
  localparam logic [PC_W-1:0] PC_END  = PC_W'(END_ADDR);

  typedef enum logic [1:0] {IDLE, RUN, DONE, FAULT} state_t;

  state_t            state, state_nx;
  logic [PC_W-1:0]   pc, pc_nx;
  logic [SP_W-1:0]   sp, sp_nx, sp_m1;
  logic [PC_W-1:0]   stk [STK_D];
  logic [PC_W-1:0]   lut [2**LUT_AW];
  logic [PC_W-1:0]   lut_rd;
  logic [IX_W-1:0]   push_ix, pop_ix;
  logic              push, start;
  logic [15:0]       cnt;

  // Combinational LUT read sees the pre-write contents on a same-cycle write.
  assign lut_rd  = lut[bus.lut_idx];
  assign sp_m1   = sp - 1'b1;
  assign push_ix = sp[IX_W-1:0];
  assign pop_ix  = sp_m1[IX_W-1:0];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state and PC/stack-pointer update; END check outranks stall and all controls.
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    sp_nx    = sp;
    push     = 1'b0;
    start    = 1'b0;
    case (state)
      IDLE: if (bus.req) begin
        state_nx = RUN;
        start    = 1'b1;
        pc_nx    = '0;
        sp_nx    = '0;
      end
      RUN: begin
        if (pc == PC_END) begin
          state_nx = DONE;
        end else if (!bus.stall) begin
          if (bus.halt) begin
            state_nx = DONE;
          end else if (bus.ret_en) begin
            if (sp == '0) state_nx = FAULT;
            else begin
              sp_nx = sp_m1;
              pc_nx = stk[pop_ix];
            end
          end else if (bus.call_en) begin
            if (sp == SP_FULL) state_nx = FAULT;
            else begin
              push  = 1'b1;
              sp_nx = sp + 1'b1;
              pc_nx = lut_rd;
            end
          end else if (bus.abs_en) begin
            pc_nx = lut_rd;
          end else if (bus.br_en) begin
            pc_nx = pc + lut_rd;
          end else begin
            pc_nx = pc + 1'b1;
          end
        end
      end
      DONE, FAULT: if (!bus.req) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // PC, stack pointer and return-address stack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= '0;
      sp <= '0;
      for (int i = 0; i < STK_D; i++) stk[i] <= '0;
    end else begin
      pc <= pc_nx;
      sp <= sp_nx;
      if (push) stk[push_ix] <= pc + 1'b1;
    end
  end

  // Jump-target LUT, writable in every state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2**LUT_AW; i++) lut[i] <= '0;
    end else if (bus.lut_we) begin
      lut[bus.lut_waddr] <= bus.lut_wdata;
    end
  end

  // Saturating RUN-cycle counter, cleared on program start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            cnt <= '0;
    else if (start)                       cnt <= '0;
    else if (state == RUN && cnt != '1)   cnt <= cnt + 1'b1;
  end

  assign bus.prog_ctr = pc;
  assign bus.run      = (state == RUN);
  assign bus.done     = (state == DONE);
  assign bus.fault    = (state == FAULT);
  assign bus.cyc_cnt  = cnt;
endmodule

// File: doc/fetch_seq.md
FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 Parameter PC_W, 12, program counter width in bits.
REQ-002 Parameter LUT_AW, 3, jump-target LUT address width; the LUT has 2^LUT_AW entries of PC_W bits.
REQ-003 Parameter STK_D, 4, return-address stack depth (entries).
REQ-004 Parameter END_ADDR, 128, PC value that ends a program.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 req  in  1  start request from the host.
REQ-008 stall  in  1  hold the PC for this cycle.
REQ-009 br_en  in  1  relative branch taken.
REQ-010 abs_en  in  1  absolute jump.
REQ-011 call_en  in  1  subroutine call.
REQ-012 ret_en  in  1  subroutine return.
REQ-013 halt  in  1  instruction-driven stop.
REQ-014 lut_idx  in  LUT_AW  LUT entry selected for br/abs/call.
REQ-015 lut_we  in  1  LUT write enable.
REQ-016 lut_waddr  in  LUT_AW  LUT write address.
REQ-017 lut_wdata  in  PC_W  LUT write data.
REQ-018 prog_ctr  out  PC_W  current fetch address.
REQ-019 run  out  1  high when state is RUN.
REQ-020 done  out  1  high when state is DONE.
REQ-021 fault  out  1  high when state is FAULT.
REQ-022 cyc_cnt  out  16  count of RUN cycles in the current or last program.

Function
REQ-023 States: IDLE, RUN, DONE, FAULT, held in a registered state machine.
REQ-024 IDLE: if req=1, go to RUN next cycle with prog_ctr=0, stack emptied, cyc_cnt=0.
REQ-025 In RUN, control inputs take effect only when stall=0; if stall=1, prog_ctr, stack and state are held and cyc_cnt still increments.
REQ-026 RUN priority, highest first: halt, ret_en, call_en, abs_en, br_en, sequential (prog_ctr+1); only the highest-priority asserted action executes.
REQ-027 halt: go to DONE; prog_ctr is held.
REQ-028 ret_en: if the stack is non-empty, pop and load prog_ctr with the popped value; if it is empty, go to FAULT with prog_ctr held.
REQ-029 call_en: if the stack is not full, push prog_ctr+1 and load prog_ctr with LUT[lut_idx]; if it is full, go to FAULT with prog_ctr held and the stack unchanged.
REQ-030 abs_en: prog_ctr <= LUT[lut_idx].
REQ-031 br_en: prog_ctr <= prog_ctr + LUT[lut_idx], with the LUT entry treated as two's-complement PC_W bits and the sum taken modulo 2^PC_W.
REQ-032 Sequential +1 wraps modulo 2^PC_W.
REQ-033 When RUN is entered (prog_ctr=0) or a RUN update yields prog_ctr==END_ADDR, the next cycle is DONE; stall does not suppress the END_ADDR check on the current prog_ctr.
REQ-034 DONE and FAULT: prog_ctr held; leave to IDLE only in the cycle after req is sampled 0 (four-phase handshake), so a req still high from the start cycle does not restart the program.
REQ-035 cyc_cnt increments once per RUN cycle, saturates at 16'hFFFF, and holds in IDLE, DONE and FAULT until the next start.
REQ-036 LUT writes occur on any cycle in any state; a same-cycle read of the entry being written returns the old value.
REQ-037 The stack holds up to STK_D entries; after STK_D pushes without a pop, it is full; a full-depth call/return sequence followed by a pop restores exact LIFO order.
REQ-038 Inputs other than req and the lut_* ports are ignored outside RUN.

Reset
REQ-039 On reset=1, without waiting for clk: state=IDLE, prog_ctr=0, run=0, done=0, fault=0, cyc_cnt=0, stack empty, all LUT entries 0.
REQ-040 Reset asserted mid-RUN aborts the program immediately.
REQ-041 After reset deasserts, req must again be seen high in IDLE before RUN is entered.

Verification
REQ-042 Basic run: req=1, no controls -> prog_ctr steps 0,1,...,128; done=1 the cycle after 128 is reached; cyc_cnt=129; req=0 -> IDLE.
REQ-043 Relative branch: LUT[2]=12'hFFE (i.e. -2); br_en with lut_idx=2 at prog_ctr=5 -> prog_ctr=3; from prog_ctr=0 -> prog_ctr=12'hFFE (wrap).
REQ-044 Call/return: STK_D=4; four nested calls to LUT[1]=40 from PCs 10,41,41,41 -> returns yield 42,42,42,11; a fifth call while full -> fault=1.
REQ-045 Priority and stall: halt+abs_en together -> DONE with prog_ctr unchanged; stall=1 for 3 cycles with abs_en -> PC held 3 cycles, cyc_cnt +3.
REQ-046 Reset at cycle 20 of RUN, asynchronously between clock edges -> outputs 0 / IDLE before the next clk edge; ret_en on an empty stack -> FAULT, cleared by req=0.
